instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 90 +++++++++
 tb/tb_instr_fetch_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: credit-limited instruction fetcher with a tagged decode queue and redirect discard.
// Optional IFETCH_STALL_CNT_EN adds a saturating decoder-starvation counter on stall_cnt.
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [5:0]  dec_opcode,
  output logic [5:0]  dec_func,
`ifdef IFETCH_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0] QD = (CW + 1)'(QDEPTH);
  logic [31:0] pc, rsp_pc, new_pc;
  logic [CW-1:0] cnt, inf, disc, inf_n;
  logic [AW-1:0] head, tail;
  logic [31:0] q_instr [QDEPTH];
  logic [31:0] q_pc [QDEPTH];
  logic [CW:0] used;
  logic acc, push, pop;
  assign used = {1'b0, cnt} + {1'b0, inf};
  assign imem_req_valid = !rst && used < QD;
  assign imem_req_addr = pc;
  assign acc = imem_req_valid && imem_req_ready;
  assign push = imem_rsp_valid && !redirect && disc == '0;
  assign dec_valid = cnt != '0;
  assign pop = dec_valid && dec_ready;
  assign dec_instr = dec_valid ? q_instr[head] : '0;
  assign dec_pc = dec_valid ? q_pc[head] : '0;
  assign dec_opcode = dec_instr[31:26];
  assign dec_func = dec_instr[5:0];
  assign inf_n = inf + CW'(acc) - CW'(imem_rsp_valid);
  assign new_pc = redirect_pc & ~32'h3;
  // Every request still in flight at a redirect is stale, so the discard count becomes the new in-flight count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      cnt <= '0;
      inf <= '0;
      disc <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      inf <= inf_n;
      if (redirect) begin
        pc <= new_pc;
        rsp_pc <= new_pc;
        disc <= inf_n;
        head <= head + AW'(pop);
        tail <= head + AW'(pop);
        cnt <= '0;
      end else begin
        if (acc) pc <= pc + 32'd4;
        if (push) rsp_pc <= rsp_pc + 32'd4;
        if (imem_rsp_valid && disc != '0) disc <= disc - 1'b1;
        head <= head + AW'(pop);
        tail <= tail + AW'(push);
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail] <= imem_rsp_data;
      q_pc[tail] <= rsp_pc;
    end
  end
`ifdef IFETCH_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (dec_ready && !dec_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed bench with an in-order memory model and a stream-level reference of the fetcher.
module tb_instr_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int QDEPTH = 2;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready = 1;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic dec_valid, dec_ready = 1;
  logic [31:0] dec_instr, dec_pc;
  logic [5:0] dec_opcode, dec_func;
  logic redirect = 0;
  logic [31:0] redirect_pc = 0;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  instr_fetch_queue #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_opcode(dec_opcode), .dec_func(dec_func),
`ifdef IFETCH_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .redirect(redirect), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; int due; int g;} mreq_t;
  mreq_t mq[$];
  int tests = 0, fails = 0, cnum = 0, lat = 1, gen = 0, rsp_g = 0, q_n = 0;
  logic [31:0] exp_req = RESET_PC, exp_dec = RESET_PC, s_cnt = 0, hold;
  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
    cnum++;
    redirect = 0;
    imem_rsp_valid = 0;
    if (mq.size() != 0 && mq[0].due <= cnum) begin
      imem_rsp_valid = 1;
      imem_rsp_data = f(mq[0].addr);
      rsp_g = mq[0].g;
      void'(mq.pop_front());
    end
  endtask
  // Reference: decode stream runs sequentially from the last redirect target; only responses to post-redirect requests fill it.
  logic p_rst = 1, p_dv = 0, p_dr = 0, p_red = 0, p_rv = 0, p_rr = 0;
  logic [31:0] p_pc = 0, p_ins = 0, p_addr = 0;
  always @(negedge clk) begin
    if (rst) begin
      q_n = 0; gen++; exp_req = RESET_PC; exp_dec = RESET_PC; s_cnt = 0;
    end else begin
      logic [31:0] e;
      int infl;
      e = f(exp_dec);
      infl = mq.size() + (imem_rsp_valid ? 1 : 0);
`ifdef IFETCH_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, s_cnt);
`endif
      chk("req_credit", 32'(imem_req_valid), 32'(q_n + infl < QDEPTH));
      chk("dec_valid", 32'(dec_valid), 32'(q_n != 0));
      if (dec_valid) begin
        chk("dec_pc", dec_pc, exp_dec);
        chk("dec_instr", dec_instr, e);
        chk("dec_opcode", 32'(dec_opcode), 32'(e[31:26]));
        chk("dec_func", 32'(dec_func), 32'(e[5:0]));
      end
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
      if (!p_rst && p_dv && !p_dr && !p_red) begin
        chk("dec_hold_valid", 32'(dec_valid), 1);
        chk("dec_hold_pc", dec_pc, p_pc);
        chk("dec_hold_instr", dec_instr, p_ins);
      end
      if (!p_rst && p_rv && !p_rr && !p_red) begin
        chk("req_hold_valid", 32'(imem_req_valid), 1);
        chk("req_hold_addr", imem_req_addr, p_addr);
      end
      if (dec_ready && !dec_valid && s_cnt != '1) s_cnt++;
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{imem_req_addr, cnum + lat, gen});
        exp_req = imem_req_addr + 4;
      end
      if (dec_valid && dec_ready) begin q_n--; exp_dec += 4; end
      if (imem_rsp_valid && rsp_g == gen && !redirect) q_n++;
      if (redirect) begin
        gen++; q_n = 0; exp_req = redirect_pc & ~32'h3; exp_dec = exp_req;
      end
    end
    p_rst = rst; p_dv = dec_valid; p_dr = dec_ready; p_red = redirect;
    p_rv = imem_req_valid; p_rr = imem_req_ready; p_pc = dec_pc; p_ins = dec_instr; p_addr = imem_req_addr;
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dec_valid", 32'(dec_valid), 0);
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_dec_instr", dec_instr, 0);
    chk("rst_dec_pc", dec_pc, 0);
    rst = 0;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    cyc();
    chk("req1_addr", imem_req_addr, 32'h4);
    cyc();
    chk("lat2_dec_valid", 32'(dec_valid), 1);
    chk("lat2_dec_pc", dec_pc, 32'h0);
    cyc();
    chk("req2_addr", imem_req_addr, 32'h8);
    chk("dec_pc_seq", dec_pc, 32'h4);
    for (int i = 0; i < 12; i++) begin
      imem_req_ready = (i % 3 != 1);
      cyc();
    end
    imem_req_ready = 1;
    dec_ready = 0;
    cyc();
    hold = dec_instr;
    repeat (10) cyc();
    chk("stall_full_valid", 32'(dec_valid), 1);
    chk("stall_no_req", 32'(imem_req_valid), 0);
    chk("stall_instr_hold", dec_instr, hold);
    dec_ready = 1;
    repeat (6) cyc();
    lat = 2;
    for (int i = 0; i < 40 && !(mq.size() + 32'(imem_rsp_valid) == 2 && !dec_valid); i++) cyc();
    chk("two_outstanding", mq.size() + 32'(imem_rsp_valid), 2);
    redirect = 1; redirect_pc = 32'h0000_0103;
    cyc();
    for (int i = 0; i < 20 && !imem_req_valid; i++) cyc();
    chk("redir_req_addr", imem_req_addr, 32'h100);
    for (int i = 0; i < 20 && !dec_valid; i++) cyc();
    chk("redir_dec_pc", dec_pc, 32'h100);
    lat = 1;
    for (int i = 0; i < 40 && !(imem_rsp_valid && dec_valid); i++) cyc();
    chk("rsp_and_pop_found", 32'(imem_rsp_valid && dec_valid), 1);
    redirect = 1; redirect_pc = 32'h0000_0200;
    cyc();
    chk("redir_flush_empty", 32'(dec_valid), 0);
    repeat (4) cyc();
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    for (int i = 0; i < 20 && !imem_req_valid; i++) cyc();
    chk("wrap_req_top", imem_req_addr, 32'hFFFF_FFFC);
    cyc();
    for (int i = 0; i < 20 && !imem_req_valid; i++) cyc();
    chk("wrap_req_zero", imem_req_addr, 32'h0);
    for (int i = 0; i < 20 && !dec_valid; i++) cyc();
    chk("wrap_dec_pc", dec_pc, 32'hFFFF_FFFC);
    repeat (3) cyc();
    dec_ready = 0;
    for (int i = 0; i < 40 && !(dec_valid && !imem_req_valid && mq.size() == 0 && !imem_rsp_valid); i++) cyc();
    chk("full_before_rst", 32'(dec_valid && !imem_req_valid), 1);
    @(posedge clk);
    #3;
    rst = 1;
    mq.delete();
    imem_rsp_valid = 0;
    #1;
    chk("arst_dec_valid", 32'(dec_valid), 0);
    chk("arst_req_valid", 32'(imem_req_valid), 0);
    chk("arst_dec_instr", dec_instr, 0);
    chk("arst_dec_pc", dec_pc, 0);
    repeat (2) cyc();
    rst = 0;
    dec_ready = 1;
    #1;
    chk("post_rst_req_valid", 32'(imem_req_valid), 1);
    chk("post_rst_req_addr", imem_req_addr, RESET_PC);
`ifdef IFETCH_STALL_CNT_EN
    chk("post_rst_stall_cnt", stall_cnt, 0);
`endif
    repeat (10) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
